// File: rtl/arbitro_mux_rr4.sv
// Round-robin arbiter for a shared 4:1 mux: registered one-hot grant/select and registered data with valid.
// Optional forced rotation after MAX_HOLD grant cycles when built with ARB_MUX_TIMEOUT_EN.
module arbitro_mux_rr4 #(
  parameter int ancho    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [ancho-1:0] D0,
  input  logic [ancho-1:0] D1,
  input  logic [ancho-1:0] D2,
  input  logic [ancho-1:0] D3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [ancho-1:0] Y,
  output logic             vld
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [ancho-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic [ancho-1:0] mux_dat;

  logic [3:0] others;
  logic       release_c;
  logic       force_rot;
  logic [2:0] pick_r;

  // Returns {found, index} of the first set bit at or after p+1, wrapping 3 -> 0.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!pick[2] && r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    others    = req & ~(4'b0001 << sel_q);
    release_c = ~req[sel_q];
`ifdef ARB_MUX_TIMEOUT_EN
    force_rot = (hold_q == HW'(MAX_HOLD)) && (|others);
`else
    force_rot = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pick_r  = 3'b000;
    case (state_q)
      IDLE: begin
        pick_r = pick(req, ptr_q);
        gnt_d  = 4'b0000;
        if (pick_r[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_r[1:0];
          sel_d   = pick_r[1:0];
          ptr_d   = pick_r[1:0];
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (release_c || force_rot) begin
          // Holder is excluded so a forced rotation cannot re-grant it.
          pick_r = pick(others, ptr_q);
          if (pick_r[2]) begin
            gnt_d  = 4'b0001 << pick_r[1:0];
            sel_d  = pick_r[1:0];
            ptr_d  = pick_r[1:0];
            hold_d = HW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_dat = D0;
      2'd1:    mux_dat = D1;
      2'd2:    mux_dat = D2;
      default: mux_dat = D3;
    endcase
    vld_d = (state_q == GRANT);
    y_d   = (state_q == GRANT) ? mux_dat : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;
  assign Y   = y_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_arbitro_mux_rr4.sv
// Bench for arbitro_mux_rr4: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural owner/last-winner model.
module tb_arbitro_mux_rr4;

  localparam int MAXH = 8;
`ifdef ARB_MUX_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d [4];
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] Y;
  logic       vld;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: current owner (-1 idle), last winner, cycles held, data outputs.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_hold  = 0;
  logic [3:0] m_y     = 4'h0;
  logic       m_vld   = 1'b0;

  arbitro_mux_rr4 #(.ancho(4), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .gnt(gnt), .sel(sel), .Y(Y), .vld(vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    logic [3:0] oth;
    if (rst) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_y = 4'h0; m_vld = 1'b0;
    end else begin
      m_vld = (m_owner >= 0);
      if (m_owner >= 0) m_y = d[m_owner];
      if (m_owner < 0) begin
        w = first_from(req, (m_last + 1) % 4);
        if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
      end else begin
        oth = req;
        oth[m_owner] = 1'b0;
        if (!req[m_owner] || (TIMEOUT && m_hold == MAXH && oth != 4'b0)) begin
          w = first_from(oth, (m_owner + 1) % 4);
          if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
          else m_owner = -1;
        end else if (m_hold < MAXH) begin
          m_hold = m_hold + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt", gnt, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      if (m_owner >= 0) chk("model_sel", sel, m_owner);
      chk("model_vld", vld, m_vld);
      chk("model_y", Y, m_y);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 4'h0;
    @(negedge clk);

    // Reset then single request
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'b00);
    chk("rst_y", Y, 4'h0);
    chk("rst_vld", vld, 1'b0);
    rst = 1'b0; req = 4'b0100; d[2] = 4'hA;
    cyc(1);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", sel, 2'd2);
    cyc(1);
    chk("single_y", Y, 4'hA);
    chk("single_vld", vld, 1'b1);

    // All request from reset, each drops right after its grant
    do_reset();
    req = 4'b1111; cyc(1); chk("seq_g0", gnt, 4'b0001);
    req = 4'b1110; cyc(1); chk("seq_g1", gnt, 4'b0010);
    req = 4'b1100; cyc(1); chk("seq_g2", gnt, 4'b0100);
    req = 4'b1000; cyc(1); chk("seq_g3", gnt, 4'b1000);
    req = 4'b0000; cyc(1); chk("seq_idle", gnt, 4'b0000);

    // Rotation fairness from ptr=1
    do_reset();
    req = 4'b0010; cyc(1); chk("rot_g1", gnt, 4'b0010);
    req = 4'b0000; cyc(1);
    req = 4'b1011; cyc(1); chk("rot_g3", gnt, 4'b1000);
    req = 4'b0011; cyc(1); chk("rot_g0", gnt, 4'b0001);
    req = 4'b0010; cyc(1); chk("rot_g1b", gnt, 4'b0010);
    req = 4'b0000; cyc(2);

    // Long hold by requester 0 with requester 1 waiting
    do_reset();
    req = 4'b0001; cyc(1); chk("hold_c1", gnt, 4'b0001);
    req = 4'b0011;
    for (int i = 2; i <= MAXH; i++) begin
      cyc(1);
      chk("hold_keep", gnt, 4'b0001);
    end
    cyc(1);
    chk("hold_after", gnt, TIMEOUT ? 4'b0010 : 4'b0001);
    req = 4'b0000; cyc(2);

    // Release to idle: Y keeps its last value
    do_reset();
    d[2] = 4'h5;
    req = 4'b0100; cyc(2);
    req = 4'b0000; cyc(1);
    chk("rel_gnt", gnt, 4'b0000);
    d[2] = 4'h7;
    cyc(1);
    chk("rel_vld", vld, 1'b0);
    chk("rel_y", Y, 4'h5);

    // Mid-grant reset
    req = 4'b0100; cyc(2);
    rst = 1'b1; cyc(1);
    chk("mrst_gnt", gnt, 4'b0000);
    chk("mrst_vld", vld, 1'b0);
    chk("mrst_y", Y, 4'h0);
    rst = 1'b0; req = 4'b0001; cyc(1);
    chk("mrst_g0", gnt, 4'b0001);
    req = 4'b0000; cyc(1);

    // Randomized traffic with sticky requests and occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) req[b] = ~req[b];
        d[b] = 4'($urandom_range(15));
      end
      rst = ($urandom_range(199) == 0);
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
